// File: rtl/dram_lsu_pkg.sv
// dram_lsu_pkg: shared size encodings, FSM states and big-endian lane offsets for dram_lsu.
package dram_lsu_pkg;
    typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_e;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;
    localparam logic [4:0] BYTE0_SHIFT = 5'd24;
    localparam logic [4:0] HALF0_SHIFT = 5'd16;
    // Big-endian: lower offsets live in the more significant bits of the word.
    function automatic logic [4:0] lane_shift(input logic [1:0] size, input logic [1:0] off);
        return (size == SZ_BYTE) ? BYTE0_SHIFT - {off, 3'b000} : (off[1] ? 5'd0 : HALF0_SHIFT);
    endfunction
endpackage

// File: rtl/dram_lsu_align.sv
// dram_lsu_align: combinational lane extract/extend for loads and lane merge for sub-word stores.
module dram_lsu_align
    import dram_lsu_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        uns_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] q_i,
    input  logic [31:0] cap_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic [31:0] wdata_o
);
    logic [4:0]  sh;
    logic [31:0] mask, lane, ext;
    logic        is_word;

    always_comb begin
        is_word = size_i[1];
        sh      = lane_shift(size_i, off_i);
        mask    = (size_i == SZ_BYTE) ? 32'h0000_00FF : 32'h0000_FFFF;
        lane    = (q_i >> sh) & mask;
        ext     = (size_i == SZ_BYTE) ? {{24{~uns_i & lane[7]}}, lane[7:0]}
                                      : {{16{~uns_i & lane[15]}}, lane[15:0]};
        rdata_o = is_word ? q_i : ext;
        wdata_o = is_word ? wdata_i : (cap_i & ~(mask << sh)) | ((wdata_i & mask) << sh);
    end
endmodule

// File: rtl/dram_lsu.sv
// dram_lsu: single-outstanding load/store unit over a word-wide synchronous memory.
// Optional DRAM_LSU_MISALIGN_TRAP_EN: misaligned/reserved-size requests respond with RSP_ERR.
module dram_lsu
    import dram_lsu_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic              REQ_WE,
    input  logic [1:0]        REQ_SIZE,
    input  logic              REQ_UNS,
    input  logic [ADDR_W+1:0] REQ_ADDR,
    input  logic [31:0]       REQ_WDATA,
    output logic              RSP_VALID,
    input  logic              RSP_READY,
    output logic [31:0]       RSP_RDATA,
    output logic              RSP_ERR,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [31:0]       MEM_DATA,
    output logic              MEM_MW,
    input  logic [31:0]       MEM_Q
);
    state_e            state_q, state_d;
    logic              we_q, we_d, uns_q, uns_d, err_q, err_d;
    logic [1:0]        size_q, size_d;
    logic [ADDR_W+1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d, cap_q, cap_d, rdata_q, rdata_d;
    logic [31:0]       ld_data, st_data;
    logic              accept, misalign;

    dram_lsu_align u_align (
        .size_i  (size_q),
        .uns_i   (uns_q),
        .off_i   (addr_q[1:0]),
        .q_i     (MEM_Q),
        .cap_i   (cap_q),
        .wdata_i (wdata_q),
        .rdata_o (ld_data),
        .wdata_o (st_data)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= SZ_BYTE;
            addr_q  <= '0;
            wdata_q <= '0;
            cap_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            uns_q   <= uns_d;
            err_q   <= err_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cap_q   <= cap_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        accept = (state_q == IDLE) && REQ_VALID;
`ifdef DRAM_LSU_MISALIGN_TRAP_EN
        misalign = (REQ_SIZE == SZ_RSVD) || (REQ_SIZE == SZ_HALF && REQ_ADDR[0])
                || (REQ_SIZE == SZ_WORD && REQ_ADDR[1:0] != 2'b00);
`else
        misalign = 1'b0;
`endif
        state_d = (state_q == IDLE) ? (!accept ? IDLE : misalign ? RESP : (REQ_WE && REQ_SIZE[1]) ? WR : RD)
                : (state_q == RD)   ? CAP
                : (state_q == CAP)  ? (we_q ? WR : RESP)
                : (state_q == WR)   ? RESP
                : (RSP_READY ? IDLE : RESP);
        we_d    = accept ? REQ_WE : we_q;
        uns_d   = accept ? REQ_UNS : uns_q;
        size_d  = accept ? REQ_SIZE : size_q;
        addr_d  = accept ? REQ_ADDR : addr_q;
        wdata_d = accept ? REQ_WDATA : wdata_q;
        err_d   = accept ? misalign : err_q;
        cap_d   = (state_q == CAP) ? MEM_Q : cap_q;
        rdata_d = accept ? 32'h0 : (state_q == CAP && !we_q) ? ld_data : rdata_q;
    end

    always_comb begin
        REQ_READY = (state_q == IDLE);
        RSP_VALID = (state_q == RESP);
        RSP_RDATA = rdata_q;
`ifdef DRAM_LSU_MISALIGN_TRAP_EN
        RSP_ERR   = err_q;
`else
        RSP_ERR   = 1'b0;
`endif
        MEM_ADDR  = (state_q == RD || state_q == CAP || state_q == WR) ? addr_q[ADDR_W+1:2] : '0;
        MEM_MW    = (state_q == WR);
        MEM_DATA  = (state_q == WR) ? (size_q[1] ? wdata_q : st_data) : 32'h0;
    end
endmodule

// File: tb/tb_dram_lsu.sv
// tb_dram_lsu: directed self-checking bench for dram_lsu with a behavioural synchronous memory.
module tb_dram_lsu;
    localparam int ADDR_W = 8;
    logic              CLK = 1'b0;
    logic              RST;
    logic              REQ_VALID, REQ_READY, REQ_WE, REQ_UNS;
    logic [1:0]        REQ_SIZE;
    logic [ADDR_W+1:0] REQ_ADDR;
    logic [31:0]       REQ_WDATA;
    logic              RSP_VALID, RSP_READY, RSP_ERR;
    logic [31:0]       RSP_RDATA;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [31:0]       MEM_DATA, MEM_Q;
    logic              MEM_MW;
    logic [31:0]       mem [256];
    logic [31:0]       mw_last;
    int                mw_cnt = 0;
    int                pass_n = 0;
    int                tot_n = 0;

    dram_lsu #(.ADDR_W(ADDR_W)) dut (
        .CLK(CLK), .RST(RST),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE), .REQ_SIZE(REQ_SIZE),
        .REQ_UNS(REQ_UNS), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
        .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA), .MEM_MW(MEM_MW), .MEM_Q(MEM_Q)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (MEM_MW) begin
            mem[MEM_ADDR] <= MEM_DATA;
            mw_cnt        <= mw_cnt + 1;
            mw_last       <= MEM_DATA;
        end
        MEM_Q <= MEM_MW ? 32'hxxxx_xxxx : mem[MEM_ADDR];
    end

    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns, input logic [9:0] a,
                          input logic [31:0] wd, output int edges, output logic [31:0] rd, output logic err);
        @(negedge CLK);
        REQ_VALID = 1'b1; REQ_WE = we; REQ_SIZE = sz; REQ_UNS = uns; REQ_ADDR = a; REQ_WDATA = wd;
        RSP_READY = 1'b1;
        @(posedge CLK); #1;
        REQ_VALID = 1'b0;
        edges = 0;
        while (!RSP_VALID && edges < 20) begin
            @(posedge CLK); #1;
            edges++;
        end
        rd  = RSP_RDATA;
        err = RSP_ERR;
        @(posedge CLK); #1;
    endtask

    task automatic test_reset();
        RST = 1'b1; REQ_VALID = 1'b0; REQ_WE = 1'b0; REQ_SIZE = 2'b00; REQ_UNS = 1'b0;
        REQ_ADDR = '0; REQ_WDATA = '0; RSP_READY = 1'b1;
        #2;
        tot_n++; if (REQ_READY !== 1'b1) $display("FAIL reset REQ_READY got %b want 1", REQ_READY); else pass_n++;
        tot_n++; if (RSP_VALID !== 1'b0) $display("FAIL reset RSP_VALID got %b want 0", RSP_VALID); else pass_n++;
        tot_n++; if (MEM_MW !== 1'b0) $display("FAIL reset MEM_MW got %b want 0", MEM_MW); else pass_n++;
        tot_n++; if (MEM_ADDR !== 8'h00) $display("FAIL reset MEM_ADDR got %h want 00", MEM_ADDR); else pass_n++;
        tot_n++; if (MEM_DATA !== 32'h0) $display("FAIL reset MEM_DATA got %h want 0", MEM_DATA); else pass_n++;
        tot_n++; if (RSP_RDATA !== 32'h0) $display("FAIL reset RSP_RDATA got %h want 0", RSP_RDATA); else pass_n++;
        tot_n++; if (RSP_ERR !== 1'b0) $display("FAIL reset RSP_ERR got %b want 0", RSP_ERR); else pass_n++;
        @(negedge CLK); RST = 1'b0;
    endtask

    task automatic test_word_store();
        int e; logic [31:0] r; logic er;
        do_req(1'b1, 2'b10, 1'b0, 10'h014, 32'h80A1_B2C3, e, r, er);
        tot_n++; if (e !== 1) $display("FAIL wstore edges got %0d want 1", e); else pass_n++;
        tot_n++; if (mem[5] !== 32'h80A1_B2C3) $display("FAIL wstore mem5 got %h want 80a1b2c3", mem[5]); else pass_n++;
        do_req(1'b1, 2'b10, 1'b0, 10'h000, 32'hCAFE_F00D, e, r, er);
        do_req(1'b1, 2'b10, 1'b0, 10'h00C, 32'h1111_1111, e, r, er);
        tot_n++; if (mem[0] !== 32'hCAFE_F00D) $display("FAIL wstore mem0 got %h want cafef00d", mem[0]); else pass_n++;
    endtask

    task automatic test_loads();
        logic [1:0]  sz [8] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2};
        logic        un [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [9:0]  ad [8] = '{10'h15, 10'h15, 10'h14, 10'h17, 10'h14, 10'h16, 10'h16, 10'h14};
        logic [31:0] ex [8] = '{32'hFFFF_FFA1, 32'h0000_00A1, 32'hFFFF_FF80, 32'hFFFF_FFC3,
                                32'hFFFF_80A1, 32'h0000_B2C3, 32'hFFFF_B2C3, 32'h80A1_B2C3};
        int e; logic [31:0] r; logic er;
        for (int i = 0; i < 8; i++) begin
            do_req(1'b0, sz[i], un[i], ad[i], 32'h0, e, r, er);
            tot_n++; if (r !== ex[i]) $display("FAIL load%0d rdata got %h want %h", i, r, ex[i]); else pass_n++;
            tot_n++; if (e !== 2) $display("FAIL load%0d edges got %0d want 2", i, e); else pass_n++;
        end
    endtask

    task automatic test_subword_store();
        int e, m0; logic [31:0] r; logic er;
        m0 = mw_cnt;
        do_req(1'b1, 2'b01, 1'b0, 10'h016, 32'h0000_1234, e, r, er);
        tot_n++; if (e !== 3) $display("FAIL hstore edges got %0d want 3", e); else pass_n++;
        tot_n++; if (r !== 32'h0) $display("FAIL hstore rdata got %h want 0", r); else pass_n++;
        tot_n++; if (mw_cnt - m0 !== 1) $display("FAIL hstore pulses got %0d want 1", mw_cnt - m0); else pass_n++;
        tot_n++; if (mw_last !== 32'h80A1_1234) $display("FAIL hstore wdata got %h want 80a11234", mw_last); else pass_n++;
        do_req(1'b0, 2'b10, 1'b0, 10'h014, 32'h0, e, r, er);
        tot_n++; if (r !== 32'h80A1_1234) $display("FAIL hstore readback got %h want 80a11234", r); else pass_n++;
        do_req(1'b1, 2'b00, 1'b0, 10'h015, 32'hFFFF_FFAB, e, r, er);
        tot_n++; if (mem[5] !== 32'h80AB_1234) $display("FAIL bstore mem5 got %h want 80ab1234", mem[5]); else pass_n++;
    endtask

    task automatic test_rsp_hold();
        int bad = 0; int m0;
        m0 = mw_cnt;
        @(negedge CLK);
        REQ_VALID = 1'b1; REQ_WE = 1'b1; REQ_SIZE = 2'b10; REQ_UNS = 1'b0;
        REQ_ADDR = 10'h008; REQ_WDATA = 32'hDEAD_BEEF; RSP_READY = 1'b0;
        @(posedge CLK); #1;
        REQ_ADDR = 10'h020; REQ_WDATA = 32'h0BAD_F00D;
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK); #1;
            if (RSP_VALID !== 1'b1 || REQ_READY !== 1'b0 || RSP_RDATA !== 32'h0) bad++;
        end
        tot_n++; if (bad !== 0) $display("FAIL hold cycles bad got %0d want 0", bad); else pass_n++;
        @(negedge CLK); RSP_READY = 1'b1; REQ_VALID = 1'b0;
        @(posedge CLK); #1;
        tot_n++; if (RSP_VALID !== 1'b0 || REQ_READY !== 1'b1)
            $display("FAIL hold release valid/ready got %b%b want 01", RSP_VALID, REQ_READY); else pass_n++;
        tot_n++; if (mem[2] !== 32'hDEAD_BEEF) $display("FAIL hold mem2 got %h want deadbeef", mem[2]); else pass_n++;
        tot_n++; if (mw_cnt - m0 !== 1) $display("FAIL hold pulses got %0d want 1", mw_cnt - m0); else pass_n++;
    endtask

    task automatic test_reset_in_wr();
        int bad = 0;
        @(negedge CLK);
        REQ_VALID = 1'b1; REQ_WE = 1'b1; REQ_SIZE = 2'b10; REQ_ADDR = 10'h00C; REQ_WDATA = 32'hAAAA_AAAA;
        RSP_READY = 1'b1;
        @(posedge CLK); #1;
        REQ_VALID = 1'b0;
        tot_n++; if (MEM_MW !== 1'b1) $display("FAIL rstwr in WR MEM_MW got %b want 1", MEM_MW); else pass_n++;
        #2 RST = 1'b1;
        #1;
        tot_n++; if (MEM_MW !== 1'b0) $display("FAIL rstwr async MEM_MW got %b want 0", MEM_MW); else pass_n++;
        tot_n++; if (RSP_VALID !== 1'b0) $display("FAIL rstwr RSP_VALID got %b want 0", RSP_VALID); else pass_n++;
        @(posedge CLK);
        @(negedge CLK); RST = 1'b0;
        #1;
        tot_n++; if (REQ_READY !== 1'b1) $display("FAIL rstwr REQ_READY got %b want 1", REQ_READY); else pass_n++;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #1;
            if (RSP_VALID !== 1'b0) bad++;
        end
        tot_n++; if (bad !== 0) $display("FAIL rstwr stray response got %0d want 0", bad); else pass_n++;
        tot_n++; if (mem[3] !== 32'h1111_1111) $display("FAIL rstwr mem3 got %h want 11111111", mem[3]); else pass_n++;
    endtask

    task automatic test_misalign();
        int e, m0; logic [31:0] r; logic er;
        m0 = mw_cnt;
        do_req(1'b0, 2'b10, 1'b0, 10'h002, 32'h0, e, r, er);
`ifdef DRAM_LSU_MISALIGN_TRAP_EN
        tot_n++; if (er !== 1'b1) $display("FAIL misalign err got %b want 1", er); else pass_n++;
        tot_n++; if (r !== 32'h0) $display("FAIL misalign rdata got %h want 0", r); else pass_n++;
        tot_n++; if (e !== 0) $display("FAIL misalign edges after accept got %0d want 0", e); else pass_n++;
`else
        tot_n++; if (er !== 1'b0) $display("FAIL misalign err got %b want 0", er); else pass_n++;
        tot_n++; if (r !== 32'hCAFE_F00D) $display("FAIL misalign rdata got %h want cafef00d", r); else pass_n++;
        tot_n++; if (e !== 2) $display("FAIL misalign edges got %0d want 2", e); else pass_n++;
`endif
        tot_n++; if (mw_cnt !== m0) $display("FAIL misalign pulses got %0d want 0", mw_cnt - m0); else pass_n++;
    endtask

    initial begin
        test_reset();
        test_word_store();
        test_loads();
        test_subword_store();
        test_rsp_hold();
        test_reset_in_wr();
        test_misalign();
        $display("%0d/%0d checks passed", pass_n, tot_n);
        $finish;
    end
endmodule

// File: doc/dram_lsu.md
DRAM_LSU -- requirements
Module: dram_lsu

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, the memory word-address width (byte address is ADDR_W+2 bits).
REQ-002 SHALL have port CLK, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port RST, input, 1, the reset: asynchronous, active-high.
REQ-004 SHALL have ports REQ_VALID in 1, REQ_READY out 1, REQ_WE in 1 (1=store), REQ_SIZE in 2 (00 byte, 01 half, 10 word), REQ_UNS in 1 (zero-extend load), REQ_ADDR in ADDR_W+2 (byte address), REQ_WDATA in 32.
REQ-005 SHALL have ports RSP_VALID out 1, RSP_READY in 1, RSP_RDATA out 32, RSP_ERR out 1.
REQ-006 SHALL have memory-side ports MEM_ADDR out ADDR_W, MEM_DATA out 32, MEM_MW out 1, MEM_Q in 32, driving a word-wide synchronous data memory: read data appears on MEM_Q the cycle after the edge sampling MEM_ADDR with MEM_MW=0; MEM_Q is undefined after a write edge.

Function
REQ-007 SHALL implement FSM states IDLE, RD, CAP, WR, RESP; REQ_READY=1 only in IDLE.
REQ-008 SHALL accept a request on an edge with REQ_VALID=1 in IDLE, registering WE, SIZE, UNS, ADDR, WDATA.
REQ-009 SHALL transition IDLE->RD on an accepted load or sub-word store, IDLE->WR on an accepted word store.
REQ-010 SHALL drive MEM_ADDR = registered REQ_ADDR[ADDR_W+1:2] in RD, CAP and WR, with MEM_MW=0 everywhere except WR.
REQ-011 SHALL go RD->CAP unconditionally; in CAP sample MEM_Q, then for loads go to RESP, and for sub-word stores go to WR.
REQ-012 SHALL use big-endian lanes: byte offset 0 = bits 31:24, offset 3 = bits 7:0; half offset 0 (ADDR[1]=0) = bits 31:16.
REQ-013 SHALL on loads right-justify the selected lane into RSP_RDATA, sign-extending unless UNS=1; word loads pass MEM_Q unchanged.
REQ-014 SHALL in WR assert MEM_MW=1 for exactly one cycle with MEM_DATA = REQ_WDATA (word) or MEM_Q captured in CAP with the addressed lane replaced by the low bits of REQ_WDATA (sub-word), then go to RESP.
REQ-015 SHALL hold RSP_VALID=1 in RESP until an edge with RSP_READY=1, then return to IDLE; RSP_RDATA/RSP_ERR stable while RSP_VALID=1; stores return RSP_RDATA=0.
REQ-016 SHALL assert RSP_VALID after 2 edges following acceptance for a load, 3 edges for a sub-word store, and 1 edge for a word store (no back-to-back acceptance; next accept earliest the edge after the RESP handshake).
REQ-017 SHALL ignore REQ_VALID outside IDLE; requests arriving while busy remain pending on the requester side.

Reset
REQ-018 SHALL on RST force state IDLE, RSP_VALID=0, RSP_RDATA=0, RSP_ERR=0, MEM_MW=0, MEM_ADDR=0, MEM_DATA=0, immediately and without waiting for CLK.
REQ-019 SHALL abort any in-flight operation on RST; a write in WR deasserts MEM_MW asynchronously and no response is issued.

Configuration
REQ-020 SHALL honour macro DRAM_LSU_MISALIGN_TRAP_EN: when defined, a half at odd address, a word with ADDR[1:0]!=0, or SIZE=11 SHALL go IDLE->RESP with RSP_ERR=1, RSP_RDATA=0 and no memory access.
REQ-021 SHALL without DRAM_LSU_MISALIGN_TRAP_EN tie RSP_ERR to 0, treat SIZE=11 as word, and ignore the address bits below the access size.

Structure
REQ-022 SHALL place the size encodings, FSM state type and lane-offset constants in shared package dram_lsu_pkg.
REQ-023 SHALL place combinational lane extract/extend and lane merge in one sub-module dram_lsu_align; the FSM and registers stay in dram_lsu.

Verification
REQ-024 SHALL cover: mem[5]=0x80A1B2C3; load byte ADDR=0x15, UNS=0 -> RSP_RDATA=0xFFFFFFA1 after 2 edges; UNS=1 -> 0x000000A1.
REQ-025 SHALL cover: mem[5]=0x80A1B2C3; store half 0x1234 at ADDR=0x16 -> a single MEM_MW pulse writing 0x80A11234, response after 3 edges, mem[5] read back 0x80A11234.
REQ-026 SHALL cover: word store 0xDEADBEEF at ADDR=0x08 with RSP_READY=0 for 4 cycles -> RSP_VALID held 4 cycles, REQ_READY=0 throughout, mem[2]=0xDEADBEEF.
REQ-027 SHALL cover: RST asserted mid-cycle while in WR -> MEM_MW=0 before the next edge, memory word unchanged, RSP_VALID=0, REQ_READY=1 after release.
REQ-028 SHALL cover, with the macro on: word load at ADDR=0x02 -> RSP_ERR=1, RSP_RDATA=0 after 1 edge, MEM_MW=0; with the macro off, the same load returns mem[0].
